// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-and-add multiplier, one partial
// product per clock, start/done handshake, 2*WIDTH-bit exact product.
// Optional build macro SIGNED_MUL_EN: treat a/b as two's complement
// (magnitudes are multiplied and the sign is applied when the product is
// registered). Without the macro the unit is purely unsigned.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`ifdef SIGNED_MUL_EN
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_r;
  logic [WIDTH-1:0]      mcand_r;
  logic [WIDTH-1:0]      acc_hi_r;
  logic [WIDTH-1:0]      acc_lo_r;
  logic [CW-1:0]         count_r;
  logic                  busy_r;
  logic                  done_r;
  logic [2*WIDTH-1:0]    product_r;

  logic [WIDTH-1:0]      mcand_load_s;
  logic [WIDTH-1:0]      mplier_load_s;
  logic [WIDTH-1:0]      addend_s;
  logic [WIDTH:0]        sum_s;
  logic [WIDTH-1:0]      acc_hi_next_s;
  logic [WIDTH-1:0]      acc_lo_next_s;
  logic [2*WIDTH-1:0]    result_s;

`ifdef SIGNED_MUL_EN
  logic                  neg_r;
  logic                  neg_load_s;

  // Two's complement magnitude; the most-negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    magnitude = v[WIDTH-1] ? (~v + ONE_W) : v;
  endfunction
`endif

  // Operand values captured when a start request is accepted.
  always_comb begin
`ifdef SIGNED_MUL_EN
    mcand_load_s  = magnitude(a);
    mplier_load_s = magnitude(b);
    neg_load_s    = a[WIDTH-1] ^ b[WIDTH-1];
`else
    mcand_load_s  = a;
    mplier_load_s = b;
`endif
  end

  // One accumulate step: WIDTH-bit add with carry, then shift the carry into acc_hi.
  always_comb begin
    addend_s      = acc_lo_r[0] ? mcand_r : {WIDTH{1'b0}};
    sum_s         = {1'b0, acc_hi_r} + {1'b0, addend_s};
    acc_hi_next_s = sum_s[WIDTH:1];
    acc_lo_next_s = {sum_s[0], acc_lo_r[WIDTH-1:1]};
  end

  // Final product as it will be registered on the last RUN step.
`ifdef SIGNED_MUL_EN
  always_comb begin
    if (neg_r) begin
      result_s = ~{acc_hi_next_s, acc_lo_next_s} + ONE_2W;
    end else begin
      result_s = {acc_hi_next_s, acc_lo_next_s};
    end
  end
`else
  always_comb begin
    result_s = {acc_hi_next_s, acc_lo_next_s};
  end
`endif

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      mcand_r   <= {WIDTH{1'b0}};
      acc_hi_r  <= {WIDTH{1'b0}};
      acc_lo_r  <= {WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {(2*WIDTH){1'b0}};
`ifdef SIGNED_MUL_EN
      neg_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            mcand_r  <= mcand_load_s;
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= mplier_load_s;
            count_r  <= {CW{1'b0}};
`ifdef SIGNED_MUL_EN
            neg_r    <= neg_load_s;
`endif
            busy_r   <= 1'b1;
            state_r  <= ST_RUN;
          end else begin
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // start is deliberately ignored here.
          acc_hi_r <= acc_hi_next_s;
          acc_lo_r <= acc_lo_next_s;
          count_r  <= count_r + CNT_ONE;
          if (count_r == CNT_LAST) begin
            product_r <= result_s;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            state_r   <= ST_RUN;
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            mcand_r  <= mcand_load_s;
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= mplier_load_s;
            count_r  <= {CW{1'b0}};
`ifdef SIGNED_MUL_EN
            neg_r    <= neg_load_s;
`endif
            busy_r   <= 1'b1;
            state_r  <= ST_RUN;
          end else begin
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Sequential unsigned (optionally signed) shift-and-add multiplier, one partial product per clock.
- Sits downstream of the team's ripple-carry adder stage; it is the first clocked arithmetic unit in the datapath.
- Reuses a WIDTH-bit adder with carry-out for each accumulate step. For WIDTH=8 this may be the existing full_adder_8_bit; otherwise a behavioural add is used.
- Produces a 2*WIDTH-bit product with a start/done handshake.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..16); product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE state
a  input  WIDTH  multiplicand; latched on accepted start
b  input  WIDTH  multiplier; latched on accepted start
busy  output  1  high while in RUN state
done  output  1  one-cycle pulse when product is valid
product  output  2*WIDTH  result; held stable until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous, at any time including mid-operation):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal accumulator, multiplicand register and cycle counter cleared.
  - Any in-flight operation is discarded.
- States:
  - IDLE: start=1 latches a and b, clears acc_hi, loads acc_lo=b, count=0, next state RUN.
  - RUN: WIDTH cycles, exactly one step per cycle:
    - {c,sum} = acc_hi + (acc_lo[0] ? mcand : 0), computed as a WIDTH-bit add with carry-out c.
    - {acc_hi,acc_lo} <= {c,sum,acc_lo} >> 1, i.e. the carry shifts into the acc_hi MSB, so no bit is lost.
    - count increments; when count==WIDTH-1, next state DONE.
  - DONE: single cycle.
    - product <= {acc_hi,acc_lo} is registered on the RUN->DONE edge, so it is visible while done=1.
    - done=1 for exactly this cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back operation), next state RUN; otherwise next state IDLE.
- Latency: start sampled at edge N, done=1 during the cycle after edge N+WIDTH+1... precisely, done is high in the cycle following edge N+WIDTH (WIDTH RUN edges). Throughput is one product per WIDTH+1 cycles.
- busy=1 exactly while in RUN. start during RUN is ignored: no latch, no restart, no effect on the result.
- Operand changes on a or b after the accepted start have no effect.
- product keeps its previous value through RUN and updates only on the RUN->DONE edge. It is never cleared except by reset.
- Width rule: the full 2*WIDTH product is always exact (max (2^WIDTH-1)^2 fits), so there is no overflow output.
- Zero operands still take the full WIDTH RUN cycles; there is no early termination.

Optional Feature:
SIGNED_MUL_EN
- Defined: a and b are two's complement.
  - On accept, latch |a| and |b| (negate via invert+1) and record neg = a[MSB]^b[MSB].
  - Run the unsigned algorithm unchanged.
  - On the RUN->DONE edge, product = neg ? (~acc+1) : acc, over 2*WIDTH bits.
  - The most-negative operand (e.g. -128 for WIDTH=8) maps to magnitude 2^(WIDTH-1) and must produce the exact result.
  - Latency is unchanged.
- Undefined: purely unsigned; no sign logic is synthesised.

Test Plan:
- WIDTH=8, start with a=13, b=11 -> busy for 8 cycles, done pulse on the 9th cycle after the start edge, product=143 (0x008F).
- a=255, b=255 -> product=65025 (0xFE01); checks the carry path into acc_hi on every step.
- a=0, b=200, then back-to-back start during done with a=200, b=0 -> both products 0; second busy begins the cycle after the first done; timing identical to non-zero operands.
- start with a=7, b=6; pulse start with a=3, b=3 mid-RUN -> request ignored, product=42, exactly one done pulse.
- start with a=9, b=9; assert rst_n=0 asynchronously mid-RUN (between clock edges) -> busy, done and product go to 0 immediately. After release, no done pulse appears until a new start.
- With SIGNED_MUL_EN: a=-3 (0xFD), b=5 -> 0xFFF1 (-15); a=-128, b=-128 -> 0x4000 (16384); a=127, b=-1 -> 0xFF81 (-127).
